// File: rtl/video_timing_pkg.sv
// Shared raster constants for the video clock domain: default 640x480@60 timing,
// derived totals and the fixed sprite pipeline latency that sync/de must match.
package video_timing_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    function automatic int line_total(input int vis, input int front, input int sync, input int back);
        return vis + front + sync + back;
    endfunction

    localparam int DEF_H_TOTAL = line_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int DEF_V_TOTAL = line_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

    // Count-to-ext_color latency of every sprite block.
    localparam int SPRITE_PIPELINE_DELAY = 9;

endpackage

// File: rtl/video_delay_line.sv
// Fixed-length shift register; reset clears every tap so stale raster state
// never leaks out after a restart.
module video_delay_line #(
    parameter int WIDTH = 3,
    parameter int DELAY = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    genvar gi;
    generate
        for (gi = 0; gi < DELAY; gi++) begin : g_tap
            logic [WIDTH-1:0] r_tap;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) r_tap <= '0;
                    else       r_tap <= i_data;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (reset) r_tap <= '0;
                    else       r_tap <= g_tap[gi-1].r_tap;
                end
            end
        end
    endgenerate

    assign o_data = g_tap[DELAY-1].r_tap;

endmodule

// File: rtl/video_timing_gen.sv
// Raster counter with sync/de delayed to match the sprite pipeline, plus
// undelayed line/frame strobes for control-side updates during blanking.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_VISIBLE      = DEF_H_VISIBLE,
    parameter int H_FRONT        = DEF_H_FRONT,
    parameter int H_SYNC         = DEF_H_SYNC,
    parameter int H_BACK         = DEF_H_BACK,
    parameter int V_VISIBLE      = DEF_V_VISIBLE,
    parameter int V_FRONT        = DEF_V_FRONT,
    parameter int V_SYNC         = DEF_V_SYNC,
    parameter int V_BACK         = DEF_V_BACK,
    parameter int SYNC_POL       = 0,
    parameter int PIPELINE_DELAY = SPRITE_PIPELINE_DELAY
) (
    input  logic               clk,
    input  logic               reset,
    output logic signed [31:0] count_h,
    output logic signed [31:0] count_v,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               line_end,
    output logic               frame_end
);

    localparam int  H_TOTAL    = line_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int  V_TOTAL    = line_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int  HS_START   = H_VISIBLE + H_FRONT;
    localparam int  HS_END     = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int  VS_START   = V_VISIBLE + V_FRONT;
    localparam int  VS_END     = V_VISIBLE + V_FRONT + V_SYNC;
    localparam bit  ACTIVE_HI  = (SYNC_POL != 0);

    logic signed [31:0] r_count_h;
    logic signed [31:0] r_count_v;
    logic signed [31:0] w_count_h_next;
    logic signed [31:0] w_count_v_next;
    logic               r_line_end;
    logic               r_frame_end;
    logic               w_h_wrap;
    logic [2:0]         w_raw;
    logic [2:0]         w_dly;

    always_comb begin
        w_h_wrap       = (r_count_h == H_TOTAL - 1);
        w_count_h_next = w_h_wrap ? 32'sd0 : r_count_h + 32'sd1;
        w_count_v_next = r_count_v;
        if (w_h_wrap) begin
            w_count_v_next = (r_count_v == V_TOTAL - 1) ? 32'sd0 : r_count_v + 32'sd1;
        end
    end

    // Strobes come from next-state values so they coincide with the counter showing H_TOTAL-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count_h   <= '0;
            r_count_v   <= '0;
            r_line_end  <= 1'b0;
            r_frame_end <= 1'b0;
        end else begin
            r_count_h   <= w_count_h_next;
            r_count_v   <= w_count_v_next;
            r_line_end  <= (w_count_h_next == H_TOTAL - 1);
            r_frame_end <= (w_count_h_next == H_TOTAL - 1) && (w_count_v_next == V_VISIBLE - 1);
        end
    end

    assign w_raw[2] = (r_count_h < H_VISIBLE) && (r_count_v < V_VISIBLE);
    assign w_raw[1] = (r_count_h >= HS_START) && (r_count_h < HS_END);
    assign w_raw[0] = (r_count_v >= VS_START) && (r_count_v < VS_END);

    video_delay_line #(
        .WIDTH (3),
        .DELAY (PIPELINE_DELAY)
    ) u_delay (
        .clk    (clk),
        .reset  (reset),
        .i_data (w_raw),
        .o_data (w_dly)
    );

    // The chain carries active-high raw values; polarity is applied only at the output.
    assign de        = w_dly[2];
    assign hsync     = ACTIVE_HI ? w_dly[1] : !w_dly[1];
    assign vsync     = ACTIVE_HI ? w_dly[0] : !w_dly[0];
    assign count_h   = r_count_h;
    assign count_v   = r_count_v;
    assign line_end  = r_line_end;
    assign frame_end = r_frame_end;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench on a shrunken 15x8 raster: instance A uses active-low syncs with a
// 9-cycle delay, instance B active-high syncs with a 1-cycle delay.
module tb_video_timing_gen;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2, HT = 15;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1, VT = 8;
    localparam int FR = HT * VT;
    localparam int DA = 9, DB = 1;

    logic clk = 1'b0;
    logic reset;

    logic signed [31:0] a_h, a_v, b_h, b_v;
    logic a_hs, a_vs, a_de, a_le, a_fe;
    logic b_hs, b_vs, b_de, b_le, b_fe;

    int total = 0;
    int bad   = 0;
    int de_cnt, hs_cnt, vs_cnt, fe_cnt;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(0), .PIPELINE_DELAY(DA)
    ) u_dut_a (
        .clk(clk), .reset(reset), .count_h(a_h), .count_v(a_v),
        .hsync(a_hs), .vsync(a_vs), .de(a_de), .line_end(a_le), .frame_end(a_fe)
    );

    video_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1), .PIPELINE_DELAY(DB)
    ) u_dut_b (
        .clk(clk), .reset(reset), .count_h(b_h), .count_v(b_v),
        .hsync(b_hs), .vsync(b_vs), .de(b_de), .line_end(b_le), .frame_end(b_fe)
    );

    function automatic int eh(input int n);
        return n % HT;
    endfunction

    function automatic int ev(input int n);
        return (n / HT) % VT;
    endfunction

    function automatic logic raw_de(input int n, input int d);
        if (n < d) return 1'b0;
        return (eh(n - d) < HV) && (ev(n - d) < VV);
    endfunction

    function automatic logic raw_hs(input int n, input int d);
        if (n < d) return 1'b0;
        return (eh(n - d) >= HV + HF) && (eh(n - d) < HV + HF + HS);
    endfunction

    function automatic logic raw_vs(input int n, input int d);
        if (n < d) return 1'b0;
        return (ev(n - d) >= VV + VF) && (ev(n - d) < VV + VF + VS);
    endfunction

    task automatic check(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s n=%0d observed=%0d expected=%0d", tag, n, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input int n);
        check("rst_a_h", n, a_h, 0);
        check("rst_a_v", n, a_v, 0);
        check("rst_a_le", n, {31'd0, a_le}, 0);
        check("rst_a_fe", n, {31'd0, a_fe}, 0);
        check("rst_a_de", n, {31'd0, a_de}, 0);
        check("rst_a_hs", n, {31'd0, a_hs}, 1);
        check("rst_a_vs", n, {31'd0, a_vs}, 1);
        check("rst_b_de", n, {31'd0, b_de}, 0);
        check("rst_b_hs", n, {31'd0, b_hs}, 0);
        check("rst_b_vs", n, {31'd0, b_vs}, 0);
    endtask

    task automatic check_cycle(input int n);
        check("a_h", n, a_h, eh(n));
        check("a_v", n, a_v, ev(n));
        check("b_h", n, b_h, eh(n));
        check("b_v", n, b_v, ev(n));
        check("a_line_end", n, {31'd0, a_le}, {31'd0, eh(n) == HT - 1});
        check("a_frame_end", n, {31'd0, a_fe}, {31'd0, (eh(n) == HT - 1) && (ev(n) == VV - 1)});
        check("b_frame_end", n, {31'd0, b_fe}, {31'd0, (eh(n) == HT - 1) && (ev(n) == VV - 1)});
        check("a_de", n, {31'd0, a_de}, {31'd0, raw_de(n, DA)});
        check("a_hsync", n, {31'd0, a_hs}, {31'd0, !raw_hs(n, DA)});
        check("a_vsync", n, {31'd0, a_vs}, {31'd0, !raw_vs(n, DA)});
        check("b_de", n, {31'd0, b_de}, {31'd0, raw_de(n, DB)});
        check("b_hsync", n, {31'd0, b_hs}, {31'd0, raw_hs(n, DB)});
        check("b_vsync", n, {31'd0, b_vs}, {31'd0, raw_vs(n, DB)});
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_reset_state(i);
        end
        $display("phase: power-on reset checked");

        // Release just after the last reset edge: this cycle is n=0 and shows (0,0).
        reset = 1'b0;
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fe_cnt = 0;
        for (int n = 0; n <= 2 * FR + 20; n++) begin
            check_cycle(n);
            if (n == 14) check("first_wrap_le", n, {31'd0, a_le}, 1);
            if (n == 15) begin
                check("wrap_h", n, a_h, 0);
                check("wrap_v", n, a_v, 1);
            end
            if (n == FR - 1) begin
                check("frame_last_h", n, a_h, HT - 1);
                check("frame_last_v", n, a_v, VT - 1);
            end
            if (n == FR) begin
                check("frame_wrap_h", n, a_h, 0);
                check("frame_wrap_v", n, a_v, 0);
            end
            if (n == DA - 1) check("a_de_before_rise", n, {31'd0, a_de}, 0);
            if (n == DA)     check("a_de_rise", n, {31'd0, a_de}, 1);
            if (n == DB)     check("b_de_rise", n, {31'd0, b_de}, 1);
            if (n >= DA && n < DA + FR) begin
                de_cnt += a_de ? 1 : 0;
                hs_cnt += a_hs ? 0 : 1;
                vs_cnt += a_vs ? 0 : 1;
            end
            if (n < 2 * FR) fe_cnt += a_fe ? 1 : 0;
            if (n < 2 * FR + 20) step();
        end
        check("de_per_frame", 0, de_cnt, HV * VV);
        check("hs_low_per_frame", 0, hs_cnt, HS * VT);
        check("vs_low_per_frame", 0, vs_cnt, VS * HT);
        check("frame_end_pulses", 0, fe_cnt, 2);
        $display("phase: two frames from reset checked");

        // Mid-frame reset, held for three cycles.
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_reset_state(100 + i);
        end
        reset = 1'b0;
        for (int n = 0; n <= 40; n++) begin
            check_cycle(n);
            if (n < DA) begin
                check("post_rst_a_hs", n, {31'd0, a_hs}, 1);
                check("post_rst_a_de", n, {31'd0, a_de}, 0);
            end
            if (n < 40) step();
        end
        $display("phase: mid-frame reset restart checked");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
